// File: rtl/deser_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | deser_pkg                                                                |
// | Shared types and constants for the serial word deserializer.             |
// | Contents: deser_state_t (output buffer state), DESER_WIDTH_DEFAULT.      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package deser_pkg;

  // Output buffer occupancy: EMPTY = no unconsumed word, FULL = Dout valid.
  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} deser_state_t;

  localparam int DESER_WIDTH_DEFAULT = 8;

endpackage : deser_pkg
`default_nettype wire

// File: rtl/serial_word_deserializer_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mod_counter                                                              |
// | Modulo-MOD up counter with enable, synchronous clear and asynchronous    |
// | active-low reset. Tc flags that the count sits at MOD-1, i.e. the next   |
// | enabled edge wraps to 0.                                                 |
// | Ports: Clk, Rst_n, En, Clr (inputs); Count, Tc (outputs)                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mod_counter #(
  parameter int MOD = 8
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   En,
  input  logic                   Clr,
  output logic [$clog2(MOD)-1:0] Count,
  output logic                   Tc
);

  localparam int              CW   = $clog2(MOD);
  localparam logic [CW-1:0]   LAST = CW'(MOD - 1);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Count <= '0;
    end else if (Clr) begin
      Count <= '0;
    end else if (En) begin
      // Explicit wrap so non-power-of-two MOD values behave correctly.
      if (Count == LAST) Count <= '0;
      else               Count <= Count + ONE;
    end
  end

  assign Tc = (Count == LAST);

endmodule : mod_counter
`default_nettype wire

// File: rtl/serial_word_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_word_deserializer                                                 |
// | Collects strobed serial bits into WIDTH-bit words and presents them on a |
// | double-buffered valid/ready interface; capture never stalls. A word that |
// | completes while the output buffer is still held is dropped and the       |
// | sticky Overrun flag is raised.                                           |
// | Ports: Clk, Rst_n (async, active-low), Din, En (bit strobe), Clr (sync   |
// |        clear), Ready (inputs); Dout, Valid, Overrun, BitCnt (outputs)    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module serial_word_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Din,
  input  logic                     En,
  input  logic                     Clr,
  input  logic                     Ready,
  output logic [WIDTH-1:0]         Dout,
  output logic                     Valid,
  output logic                     Overrun,
  output logic [$clog2(WIDTH)-1:0] BitCnt
);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_next;   // shift register contents after this edge's bit
  logic             last_bit;    // BitCnt is at WIDTH-1
  logic             complete;    // this edge finishes a word
  logic             load_dout;
  logic             set_overrun;
  deser_state_t     state;
  deser_state_t     state_next;

  // Bit counter; its terminal flag marks the final bit of a word.
  mod_counter #(
    .MOD (WIDTH)
  ) u_bit_counter (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .En    (En),
    .Clr   (Clr),
    .Count (BitCnt),
    .Tc    (last_bit)
  );

  // Shift direction decides where the first received bit ends up.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign word_next = {shreg[WIDTH-2:0], Din};
    end else begin : g_lsb_first
      assign word_next = {Din, shreg[WIDTH-1:1]};
    end
  endgenerate

  assign complete = En && last_bit && !Clr;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      shreg <= '0;
    end else if (Clr) begin
      shreg <= '0;
    end else if (En) begin
      shreg <= word_next;
    end
  end

  // Output buffer FSM: state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_EMPTY;
    end else if (Clr) begin
      state <= S_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Output buffer FSM: next state and buffer control.
  always_comb begin
    state_next  = state;
    load_dout   = 1'b0;
    set_overrun = 1'b0;
    case (state)
      S_EMPTY: begin
        if (complete) begin
          load_dout  = 1'b1;
          state_next = S_FULL;
        end
      end
      S_FULL: begin
        if (Ready) begin
          // Handshake; a word finishing on the same edge refills with no bubble.
          if (complete) load_dout  = 1'b1;
          else          state_next = S_EMPTY;
        end else if (complete) begin
          set_overrun = 1'b1;
        end
      end
      default: state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Dout    <= '0;
      Overrun <= 1'b0;
    end else if (Clr) begin
      Dout    <= '0;
      Overrun <= 1'b0;
    end else begin
      if (load_dout)   Dout    <= word_next;
      if (set_overrun) Overrun <= 1'b1;
    end
  end

  assign Valid = (state == S_FULL);

endmodule : serial_word_deserializer
`default_nettype wire

// File: tb/tb_serial_word_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_word_deserializer                                              |
// | Drives an MSB-first and an LSB-first instance (WIDTH=8) with identical   |
// | stimulus and compares every cycle against a queue-based word model,      |
// | plus directed constant checks on the key scenarios.                      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_serial_word_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         din, en, clr, ready;
  logic [W-1:0] dout_m, dout_l;
  logic         valid_m, valid_l, ovr_m, ovr_l;
  logic [2:0]   cnt_m, cnt_l;

  int tests  = 0;
  int failed = 0;

  // Reference model state
  bit           q_bits[$];
  bit           m_valid, m_ovr;
  logic [W-1:0] m_dout_m, m_dout_l;

  always #5 clk = ~clk;

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .Clk(clk), .Rst_n(rst_n), .Din(din), .En(en), .Clr(clr), .Ready(ready),
    .Dout(dout_m), .Valid(valid_m), .Overrun(ovr_m), .BitCnt(cnt_m)
  );

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .Clk(clk), .Rst_n(rst_n), .Din(din), .En(en), .Clr(clr), .Ready(ready),
    .Dout(dout_l), .Valid(valid_l), .Overrun(ovr_l), .BitCnt(cnt_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q_bits.delete();
    m_valid  = 0;
    m_ovr    = 0;
    m_dout_m = '0;
    m_dout_l = '0;
  endfunction

  // Word rules: handshake frees the buffer first, then a finished word either
  // fills the free buffer or is dropped with the overrun flag raised.
  function automatic void model_step(input bit d, input bit e, input bit c, input bit r);
    int unsigned wm, wl;
    if (c) begin
      model_reset();
      return;
    end
    if (m_valid && r) m_valid = 0;
    if (e) begin
      q_bits.push_back(d);
      if (q_bits.size() == W) begin
        wm = 0;
        wl = 0;
        for (int i = 0; i < W; i++) begin
          wm += int'(q_bits[i]) * (1 << (W - 1 - i));
          wl += int'(q_bits[i]) * (1 << i);
        end
        q_bits.delete();
        if (m_valid) begin
          m_ovr = 1;
        end else begin
          m_valid  = 1;
          m_dout_m = W'(wm);
          m_dout_l = W'(wl);
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".dout_m"},  32'(dout_m),  32'(m_dout_m));
    chk({tag, ".dout_l"},  32'(dout_l),  32'(m_dout_l));
    chk({tag, ".valid_m"}, 32'(valid_m), 32'(m_valid));
    chk({tag, ".valid_l"}, 32'(valid_l), 32'(m_valid));
    chk({tag, ".ovr_m"},   32'(ovr_m),   32'(m_ovr));
    chk({tag, ".ovr_l"},   32'(ovr_l),   32'(m_ovr));
    chk({tag, ".cnt_m"},   32'(cnt_m),   32'(q_bits.size()));
    chk({tag, ".cnt_l"},   32'(cnt_l),   32'(q_bits.size()));
  endtask

  // One clock: inputs are applied 1 time unit after an edge, the model
  // advances on the edge, outputs are sampled 1 time unit later.
  task automatic step(input string tag, input bit d, input bit e, input bit c, input bit r);
    din   = d;
    en    = e;
    clr   = c;
    ready = r;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(d, e, c, r);
    #1;
    check_all(tag);
  endtask

  // Sends w most-significant bit first; Ready follows rdy except on the last bit.
  task automatic send_word(input string tag, input logic [7:0] w, input bit rdy, input bit rdy_last);
    for (int i = W - 1; i >= 0; i--) begin
      step(tag, w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy);
    end
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] rw;
    a5 = 8'hA5;
    rst_n = 1'b0;
    din = 0; en = 0; clr = 0; ready = 0;
    model_reset();
    #1;
    check_all("por");

    // Reset applied mid-run, then an MSB-first A5
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("pre", 1'($urandom), 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    step("rst_hold", 1'b1, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b1;
    send_word("msb", a5, 1'b1, 1'b1);
    chk("msb_dout", 32'(dout_m), 32'h0000_00A5);
    chk("msb_valid", 32'(valid_m), 32'd1);
    step("msb_consume", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("msb_valid_drop", 32'(valid_m), 32'd0);

    // LSB-first A5 with En gaps
    for (int i = W - 1; i >= 0; i--) begin
      step("lsb_gap", a5[i], 1'b1, 1'b0, 1'b1);
      step("lsb_idle", 1'($urandom), 1'b0, 1'b0, 1'b1);
    end
    chk("lsb_dout", 32'(dout_l), 32'h0000_00A5);
    step("lsb_idle2", 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure overrun
    send_word("bp1", 8'h3C, 1'b0, 1'b0);
    send_word("bp2", 8'hC3, 1'b0, 1'b0);
    chk("bp_dout", 32'(dout_m), 32'h0000_003C);
    chk("bp_ovr", 32'(ovr_m), 32'd1);
    step("bp_hs", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_valid", 32'(valid_m), 32'd0);
    chk("bp_dout_hold", 32'(dout_m), 32'h0000_003C);

    // Simultaneous handshake and completion
    step("sim_clr", 1'b0, 1'b0, 1'b1, 1'b0);
    send_word("sim1", 8'h11, 1'b0, 1'b0);
    send_word("sim2", 8'h22, 1'b0, 1'b1);
    chk("sim_dout", 32'(dout_m), 32'h0000_0022);
    chk("sim_valid", 32'(valid_m), 32'd1);
    chk("sim_ovr", 32'(ovr_m), 32'd0);

    // Clear mid-word (En held high during Clr), after an overrun
    send_word("clr_ovr", 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("clr_pre", 1'($urandom), 1'b1, 1'b0, 1'b0);
    step("clr", 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_cnt", 32'(cnt_m), 32'd0);
    chk("clr_valid", 32'(valid_m), 32'd0);
    chk("clr_ovr", 32'(ovr_m), 32'd0);
    rw = 8'($urandom);
    send_word("clr_post", rw, 1'b0, 1'b0);
    chk("clr_word", 32'(dout_m), 32'(rw));

    // Asynchronous reset while FULL, between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(valid_m), 32'd0);
    chk("arst_dout", 32'(dout_m), 32'd0);
    check_all("arst");
    #2;
    step("arst_hold", 1'b1, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      step("rand", 1'($urandom), ($urandom % 4) != 0, ($urandom % 60) == 0,
           ($urandom % 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_serial_word_deserializer
`default_nettype wire

// File: doc/serial_word_deserializer.md
# serial_word_deserializer

Collects a serial bit stream into parallel words. Sits directly downstream of the enabled D flip-flop stage: that stage's registered output drives `Din`, and its enable drives `En` as the per-bit strobe. Completed words are double-buffered and offered on a valid/ready handshake, so bit capture never stalls while a word waits to be consumed.

## Interface
Parameters:
- `WIDTH`, default 8: bits per word; legal range 2–32.
- `MSB_FIRST`, default 1:
  - 1: the first bit received lands in `Dout[WIDTH-1]`.
  - 0: the first bit received lands in `Dout[0]`.

Ports:
- `Clk`  in  1  single clock; all state changes on its rising edge.
- `Rst_n`  in  1  reset, asynchronous assert, active-low.
- `Din`  in  1  serial data bit.
- `En`  in  1  bit strobe, active high; `Din` is accepted on any rising edge with `En`=1.
- `Clr`  in  1  synchronous clear, active high.
- `Ready`  in  1  consumer accepts `Dout` when `Valid`=1 and `Ready`=1.
- `Dout`  out  WIDTH  completed word.
- `Valid`  out  1  `Dout` holds an unconsumed word.
- `Overrun`  out  1  sticky flag: a completed word was dropped.
- `BitCnt`  out  $clog2(WIDTH)  number of bits collected in the current word.

## Operation
- Reset (`Rst_n`=0): all of the following are 0 immediately, independent of `Clk`:
  - shift register, `Dout`, `Valid`, `Overrun`, `BitCnt`
  - FSM state is EMPTY.
- `Clr`=1:
  - same clear as reset, except it takes effect on the next rising edge.
  - overrides `En` and `Ready` in that cycle.
- Bit capture, on each edge with `En`=1:
  - `Din` shifts into the shift register in the direction set by `MSB_FIRST`.
  - `BitCnt` increments and wraps from WIDTH-1 to 0.
- Word completion: an edge with `En`=1 and `BitCnt`=WIDTH-1.
  - The full word, including the current `Din`, is the completed word.
  - The shift register is then free to collect the next word; capture never stops.
- Output FSM, two states:
  - EMPTY (`Valid`=0): on completion, load `Dout` and go to FULL.
  - FULL (`Valid`=1): `Dout` is held stable until handshake (`Valid`&&`Ready`).
    - Handshake without completion: go to EMPTY; `Dout` keeps its last value.
    - Handshake and completion on the same edge: load `Dout` with the new word and stay FULL. No bubble, no overrun.
    - Completion without handshake: the new word is discarded, `Overrun` is set to 1, and `Dout` is unchanged.
- `Overrun` clears only on `Rst_n` or `Clr`.
- `Ready` is ignored while `Valid`=0.

## Timing
- Latency: the edge that samples the last bit also updates `Dout` and `Valid`. Both are visible in the following cycle (0 extra cycles).
- Maximum throughput: one bit per cycle (`En` held at 1), which gives one word every WIDTH cycles.
- `Valid` deasserts on the handshake edge.
- All outputs are registered; there are no combinational paths from input to output.
- `Rst_n` asserted mid-word: the partial word is lost. After release, capture restarts at `BitCnt`=0.
- `Rst_n` deassertion is assumed synchronised externally to `Clk`.

## Structure
- Shared package `deser_pkg` contains:
  - `typedef enum logic {S_EMPTY, S_FULL} deser_state_t`
  - constant `DESER_WIDTH_DEFAULT = 8`
- Sub-module `mod_counter` (parameter `MOD`, with `En`, `Clr` and async `Rst_n`): provides `BitCnt` and a terminal-count flag.
- The shift register, output register and FSM stay in the top module.

## Test plan
- Reset and MSB-first word:
  - Stimulus: `WIDTH`=8, `MSB_FIRST`=1, `Ready`=1. Assert `Rst_n`=0 mid-run, then release. Send bits 1,0,1,0,0,1,0,1 with `En`=1.
  - Response: during reset, all outputs are 0. `Dout`=8'hA5 and `Valid`=1 in the cycle after the 8th bit. `Valid`=0 one cycle later.
- LSB-first word with gaps in `En`:
  - Stimulus: `MSB_FIRST`=0, same bit sequence, `En` toggling 1/0.
  - Response: `Dout`=8'hA5, and `BitCnt` advances only on `En`=1 edges.
- Backpressure overrun:
  - Stimulus: `Ready`=0; send two words 8'h3C then 8'hC3.
  - Response: `Dout` stays 8'h3C, `Overrun`=1 after the 16th bit. Then `Ready`=1 hands over 8'h3C and `Valid`=0.
- Simultaneous handshake and completion:
  - Stimulus: continuous stream 8'h11, 8'h22. `Ready` asserted exactly on the edge that completes 8'h22.
  - Response: `Dout`=8'h22, `Valid` stays 1, `Overrun` stays 0.
- Clear mid-word:
  - Stimulus: after 5 bits, pulse `Clr`=1 with `En`=1 for one cycle.
  - Response: `BitCnt`=0, `Valid`=0, `Overrun`=0. The next 8 bits form a correct word.
- Asynchronous reset while FULL:
  - Stimulus: `Rst_n` falls between clock edges.
  - Response: `Valid`, `Dout`, `Overrun` and `BitCnt` go to 0 before the next rising edge.
